// File: rtl/cpu_run_ctrl.sv
// Run controller for single-cycle CPU bring-up: holds the core in reset, runs it under a
// watchdog, then streams the register file and a data-memory window over valid/ready.
module cpu_run_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RF_DEPTH   = 32,
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned DUMP_WORDS = 256,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        cpu_rst_o,
  input  logic                        halt_i,
  output logic [$clog2(RF_DEPTH)-1:0] rf_addr_o,
  input  logic [DATA_W-1:0]           rf_data_i,
  output logic [MEM_AW-1:0]           mem_addr_o,
  input  logic [DATA_W-1:0]           mem_data_i,
  output logic                        dump_valid_o,
  input  logic                        dump_ready_i,
  output logic [DATA_W-1:0]           dump_data_o,
  output logic                        dump_src_o,
  output logic                        dump_last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timed_out_o,
  output logic [CNT_W-1:0]            cycle_count_o
);

  localparam int unsigned RfAw = $clog2(RF_DEPTH);
  localparam int unsigned IdxW = (RfAw > MEM_AW) ? RfAw : MEM_AW;
  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [IdxW-1:0]  RfLast  = IdxW'(RF_DEPTH - 1);
  localparam logic [IdxW-1:0]  MemLast = IdxW'(DUMP_WORDS - 1);
  localparam logic [RstW-1:0]  RstLast = RstW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StReset, StRun, StDumpRf, StDumpMem, StDone} state_e;

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timed_out_q, timed_out_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d     = StReset;
          rst_cnt_d   = '0;
          idx_d       = '0;
          cnt_d       = '0;
          timed_out_d = 1'b0;
        end
      end
      StReset: begin
        if (rst_cnt_q == RstLast) state_d = StRun;
        else                      rst_cnt_d = rst_cnt_q + RstW'(1);
      end
      StRun: begin
        // Halt freezes the count and takes priority over a coincident timeout.
        if (halt_i) begin
          state_d = StDumpRf;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == Timeout) begin
            timed_out_d = 1'b1;
            state_d     = StDumpRf;
          end
        end
      end
      StDumpRf: begin
        if (dump_ready_i) begin
          if (idx_q == RfLast) begin
            idx_d   = '0;
            state_d = StDumpMem;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDumpMem: begin
        if (dump_ready_i) begin
          if (idx_q == MemLast) state_d = StDone;
          else                  idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode registered state/index, so ready never reaches valid combinationally.
  always_comb begin
    cpu_rst_o     = (state_q != StRun);
    dump_valid_o  = (state_q == StDumpRf) || (state_q == StDumpMem);
    dump_src_o    = (state_q == StDumpMem);
    dump_last_o   = (state_q == StDumpMem) && (idx_q == MemLast);
    busy_o        = (state_q != StIdle) && (state_q != StDone);
    done_o        = (state_q == StDone);
    timed_out_o   = timed_out_q;
    cycle_count_o = cnt_q;
    rf_addr_o     = (state_q == StDumpRf) ? idx_q[RfAw-1:0] : '0;
    mem_addr_o    = (state_q == StDumpMem) ? idx_q[MEM_AW-1:0] : '0;
    dump_data_o   = dump_src_o ? mem_data_i : rf_data_i;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for single-cycle CPU bring-up. It replaces the simulation-only reset/halt/dump sequencing with hardware:
- holds the CPU in reset, then releases it and counts run cycles;
- stops on `halt` or on a watchdog timeout;
- streams the register file and then a window of data memory out over a valid/ready port.

It sits between the CPU core (`halt`, `RF.Mem` and `DMEM.Mem` read ports) and a host/debug link. It is parametrised in data width, register count, dump window and timeout.

## Interface
Parameters:
- `DATA_W`, 32, width of register and memory words
- `RF_DEPTH`, 32, registers dumped (power of two, ≥2)
- `MEM_AW`, 16, data-memory word-address width
- `DUMP_WORDS`, 256, memory words dumped, from word address 0 (1..2^MEM_AW)
- `RST_CYCLES`, 2, cycles CPU reset is held (≥1)
- `TIMEOUT`, 100000, run-cycle limit (≥1)
- `CNT_W`, 32, cycle counter width (2^CNT_W > TIMEOUT)

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins a run
- `cpu_rst`  out  1  active-high reset to the CPU
- `halt`  in  1  CPU halt flag
- `rf_addr`  out  log2(RF_DEPTH)  register-file read address
- `rf_data`  in  DATA_W  combinational register read data
- `mem_addr`  out  MEM_AW  data-memory word read address
- `mem_data`  in  DATA_W  combinational memory read data
- `dump_valid`  out  1  dump word available
- `dump_ready`  in  1  sink accepts the word
- `dump_data`  out  DATA_W  dump word
- `dump_src`  out  1  0 = register file, 1 = memory
- `dump_last`  out  1  final memory word
- `busy`  out  1  high in RESET, RUN, DUMP_RF and DUMP_MEM
- `done`  out  1  high in DONE
- `timed_out`  out  1  last run ended by watchdog
- `cycle_count`  out  CNT_W  run cycles of the last or current run

## Operation
FSM states: IDLE, RESET, RUN, DUMP_RF, DUMP_MEM, DONE.

- **After `rst`:** state IDLE. Outputs: `cpu_rst`=1, `dump_valid`=0, `busy`=0, `done`=0, `timed_out`=0, `cycle_count`=0, `rf_addr`=0, `mem_addr`=0, `dump_src`=0, `dump_last`=0.
- **IDLE / DONE:**
  - `cpu_rst`=1.
  - `start` → RESET; clears `cycle_count`, `timed_out`, the reset counter and the dump index.
  - `start` is ignored in every other state.
- **RESET:** `cpu_rst`=1 for exactly RST_CYCLES cycles, then → RUN.
- **RUN:**
  - `cpu_rst`=0.
  - Each cycle, if `halt`=1 → DUMP_RF and `cycle_count` freezes.
  - Otherwise `cycle_count` increments.
  - If `halt`=0 and the incremented value equals TIMEOUT → `timed_out`=1 and → DUMP_RF.
  - Halt and timeout in the same cycle: halt wins, `timed_out`=0.
- **DUMP_RF:**
  - `cpu_rst`=1 (CPU frozen; state holds while in reset).
  - `dump_valid`=1, `dump_src`=0, `rf_addr`=index, `dump_data`=`rf_data`.
  - Handshake (`dump_valid` & `dump_ready`) advances index.
  - Index RF_DEPTH-1 accepted → index=0, → DUMP_MEM.
- **DUMP_MEM:**
  - Same as DUMP_RF with `dump_src`=1, `mem_addr`=index, `dump_data`=`mem_data`.
  - `dump_last`=1 when index=DUMP_WORDS-1.
  - Handshake on last → DONE.
- **Dump data:** `dump_data` is muxed from the read ports addressed by the registered index. It is stable while `valid` & !`ready` because the index does not change.
- **`rst` mid-run or mid-dump:** → IDLE immediately; the stream is dropped with no `dump_last`.

## Timing
- `start` sampled at edge k → `cpu_rst` falls after edge k+RST_CYCLES.
- CPU executes its first instruction in the first RUN cycle.
- `halt` high in the m-th RUN cycle (m=1 first) → `cycle_count`=m-1 and `dump_valid` rises the next cycle.
- Halt never asserted → after exactly TIMEOUT RUN cycles, `cycle_count`=TIMEOUT.
- Dump throughput: one word per cycle with `dump_ready` held high.
  - Total dump = RF_DEPTH+DUMP_WORDS cycles.
  - No bubble between the last register word and the first memory word.
- `done` rises the cycle after the last handshake. `done`, `timed_out` and `cycle_count` hold until the next `start` or `rst`.
- All outputs are registered or decoded from registered state/index; no combinational path from `dump_ready` to `dump_valid`.

## Test plan
Parameters for all scenarios: RF_DEPTH=4, DUMP_WORDS=4, RST_CYCLES=2, TIMEOUT=20.

1. **Normal halt.** `start`, CPU model raises `halt` in RUN cycle 6 → `cycle_count`=5, `timed_out`=0; 8 words in order r0..r3 then m0..m3; `dump_last` only on m3; `done`=1.
2. **Watchdog.** `halt` tied 0 → exactly 20 RUN cycles, `cycle_count`=20, `timed_out`=1, then full dump.
3. **Simultaneous halt and timeout.** `halt` first rises in RUN cycle 20 → `timed_out`=0, `cycle_count`=19.
4. **Backpressure.** Random `dump_ready` (~50%) → `dump_data`/`dump_src`/`dump_last` stable while stalled; no word dropped or duplicated; `done` after 8 handshakes.
5. **Reset mid-dump.** `rst` during DUMP_MEM index 2 → next cycle IDLE, `dump_valid`=0, all outputs at reset values; a later `start` runs cleanly.
6. **Ignored and re-armed start.** `start` pulses during RUN → no effect; `start` in DONE → `done`=0, counters cleared, second run produces an identical stream.
